// File: rtl/ipg_chunk_responder.sv
// Remote-side responder for IPG-carried memory requests: decodes READ/WRITE chunks,
// executes them against a local 32-bit word memory and queues RRESP/WACK chunks in a FWFT FIFO.
module ipg_chunk_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int FIFO_DEPTH  = 16,
    parameter int ENABLE_WACK = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         rx_chunk,
    input  logic                          rx_chunk_valid,
    output logic [DATA_WIDTH-1:0]         resp_chunk,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   err_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [3:0] {
        OP_READ  = 4'h1,
        OP_WRITE = 4'h2,
        OP_RRESP = 4'h3,
        OP_WACK  = 4'h4
    } op_e;

    op_e                   rx_op;
    logic [7:0]            rx_tag;
    logic [19:0]           rx_addr;
    logic [31:0]           rx_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  addr_ok;

    assign rx_op    = op_e'(rx_chunk[63:60]);
    assign rx_tag   = rx_chunk[59:52];
    assign rx_addr  = rx_chunk[51:32];
    assign rx_data  = rx_chunk[31:0];
    assign mem_addr = rx_addr[ADDR_WIDTH-1:0];
    assign addr_ok  = (rx_addr >> ADDR_WIDTH) == 20'd0;

    logic [31:0]           mem_q [2**ADDR_WIDTH];
    logic [31:0]           rd_data_q;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_is_read_q, s1_is_read_d;
    logic [7:0]            s1_tag_q, s1_tag_d;
    logic [19:0]           s1_addr_q, s1_addr_d;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;

    logic [15:0]           drop_q, drop_d;
    logic [15:0]           err_q, err_d;

    logic                  mem_we, rd_en, err_inc, drop_inc;
    logic                  push, pop, has_space;
    logic [LW:0]           occupancy;
    logic [DATA_WIDTH-1:0] push_data;

    // Space test uses the pre-pop level plus the stage-1 reservation, so a same-cycle pop never admits.
    assign occupancy = {1'b0, count_q} + {{LW{1'b0}}, s1_valid_q};
    assign has_space = occupancy < (LW+1)'(FIFO_DEPTH);

    always_comb begin
        mem_we       = 1'b0;
        rd_en        = 1'b0;
        err_inc      = 1'b0;
        drop_inc     = 1'b0;
        s1_valid_d   = 1'b0;
        s1_is_read_d = 1'b0;
        s1_tag_d     = rx_tag;
        s1_addr_d    = rx_addr;
        if (rx_chunk_valid) begin
            if (!((rx_op == OP_READ) || (rx_op == OP_WRITE)) || !addr_ok) begin
                err_inc = 1'b1;
            end else if (rx_op == OP_WRITE) begin
                mem_we = 1'b1;
                if (ENABLE_WACK != 0) begin
                    if (has_space) s1_valid_d = 1'b1;
                    else           drop_inc   = 1'b1;
                end
            end else if (has_space) begin
                rd_en        = 1'b1;
                s1_valid_d   = 1'b1;
                s1_is_read_d = 1'b1;
            end else begin
                drop_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= rx_data;
        if (rd_en)  rd_data_q       <= mem_q[mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_is_read_q <= 1'b0;
            s1_tag_q     <= '0;
            s1_addr_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_is_read_q <= s1_is_read_d;
            s1_tag_q     <= s1_tag_d;
            s1_addr_q    <= s1_addr_d;
        end
    end

    assign push      = s1_valid_q;
    assign pop       = resp_ready && (count_q != '0);
    assign push_data = s1_is_read_q ? {OP_RRESP, s1_tag_q, s1_addr_q, rd_data_q}
                                    : {OP_WACK,  s1_tag_q, s1_addr_q, 32'h0};

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + LW'(push) - LW'(pop);
        drop_d   = (drop_inc && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;
        err_d    = (err_inc  && (err_q  != '1)) ? err_q  + 16'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    assign resp_valid = count_q != '0;
    assign resp_chunk = resp_valid ? fifo_mem[rd_ptr_q] : '0;
    assign fifo_level = count_q;
    assign drop_count = drop_q;
    assign err_count  = err_q;

endmodule
